// File: rtl/fpga_config_loader.sv
// Framed byte-stream configuration loader: header, NBYTES payload bytes, XOR checksum.
// The fabric sees a new configuration only after the whole frame has checked out.
module fpga_config_loader #(
  parameter int         CFG_BITS = 124,
  parameter int         NBYTES   = 16,
  parameter int         TIMEOUT  = 1024,
  parameter logic [7:0] HDR      = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [CFG_BITS-1:0] cfg_bits,
  output logic                cfg_valid,
  output logic                fabric_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, HEADER, LOAD, CHECK, DONE, ERROR} state_t;
  state_t state_reg, state_next;

  logic [CNT_W-1:0]    bcnt_reg;
  logic [7:0]          chk_reg;
  logic [TO_W-1:0]     tcnt_reg;
  logic [CFG_BITS-1:0] shadow_reg;
  logic [NBYTES-1:0]   byte_we;
  logic                xfer, start_ok, load_xfer, commit, timeout_hit;

  assign busy         = (state_reg == HEADER) || (state_reg == LOAD) || (state_reg == CHECK);
  assign s_ready      = busy;
  assign done         = (state_reg == DONE);
  assign error        = (state_reg == ERROR);
  assign fabric_reset = !cfg_valid || busy;

  assign xfer      = s_valid && busy;
  assign start_ok  = start && !busy;
  assign load_xfer = xfer && (state_reg == LOAD);
  assign commit    = xfer && (state_reg == CHECK) && (s_data == chk_reg);
  // this idle cycle would be the (TIMEOUT-1)th in a row without a transfer
  assign timeout_hit = !xfer && (tcnt_reg == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) state_next = HEADER;
      end
      HEADER: begin
        if (xfer)             state_next = (s_data == HDR) ? LOAD : ERROR;
        else if (timeout_hit) state_next = ERROR;
      end
      LOAD: begin
        if (xfer) begin
          if (bcnt_reg == LAST_BYTE) state_next = CHECK;
        end else if (timeout_hit) begin
          state_next = ERROR;
        end
      end
      CHECK: begin
        if (xfer)             state_next = commit ? DONE : ERROR;
        else if (timeout_hit) state_next = ERROR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      bcnt_reg <= '0;
      chk_reg  <= '0;
      tcnt_reg <= '0;
    end else if (busy) begin
      tcnt_reg <= xfer ? '0 : tcnt_reg + 1'b1;
      if (load_xfer) begin
        bcnt_reg <= bcnt_reg + 1'b1;
        chk_reg  <= chk_reg ^ s_data;
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NBYTES; gi++) begin : g_byte_we
    assign byte_we[gi] = load_xfer && (bcnt_reg == CNT_W'(gi));
  end

  // Only the CFG_BITS low bits are stored; the padding bits of the last byte
  // still feed the checksum above.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg <= '0;
    end else begin
      for (int b = 0; b < CFG_BITS; b++) begin
        if (byte_we[b / 8]) shadow_reg[b] <= s_data[b % 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_bits  <= '0;
      cfg_valid <= 1'b0;
    end else if (commit) begin
      cfg_bits  <= shadow_reg;
      cfg_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader: directed frame table, timeout/reset sequences,
// and random frames with gaps checked against a frame-level model.
module tb_fpga_config_loader;
  localparam int         CFG_BITS = 124;
  localparam int         NBYTES   = 16;
  localparam int         TIMEOUT  = 1024;
  localparam logic [7:0] HDR      = 8'hA5;

  logic                clk = 1'b0;
  logic                reset, start, s_valid;
  logic [7:0]          s_data;
  logic                s_ready, cfg_valid, fabric_reset, busy, done, error;
  logic [CFG_BITS-1:0] cfg_bits;

  int total = 0;
  int bad   = 0;

  // frame-level model: the configuration the fabric should currently hold
  logic [CFG_BITS-1:0] m_cfg;
  logic                m_valid;

  typedef struct {
    logic [7:0]          hdr;
    logic [8*NBYTES-1:0] payload;
    logic [7:0]          chk;
    logic                exp_done;
    logic                exp_err;
    logic                exp_valid;
    logic [CFG_BITS-1:0] exp_cfg;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  fpga_config_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .cfg_bits     (cfg_bits),
    .cfg_valid    (cfg_valid),
    .fabric_reset (fabric_reset),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [CFG_BITS-1:0] act,
                           input logic [CFG_BITS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xor_bytes(input logic [8*NBYTES-1:0] pl);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < NBYTES; k++) x ^= pl[8*k +: 8];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    for (int i = 0; i < gap; i++) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      start   = noise && ($urandom_range(0, 3) == 0);
      step();
    end
    check_bit("s_ready", s_ready, 1'b1);
    check_bit("fab_rst_busy", fabric_reset, 1'b1);
    s_valid = 1'b1;
    s_data  = b;
    start   = noise && ($urandom_range(0, 3) == 0);
    step();
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] hdr, input logic [8*NBYTES-1:0] pl,
                             input logic [7:0] cb, input int max_gap, input bit noise);
    start = 1'b1;
    step();
    start = 1'b0;
    check_bit("busy_t1", busy, 1'b1);
    send_byte(hdr, int'($urandom_range(0, max_gap)), noise);
    if (hdr == HDR) begin
      for (int k = 0; k < NBYTES; k++)
        send_byte(pl[8*k +: 8], int'($urandom_range(0, max_gap)), noise);
      send_byte(cb, int'($urandom_range(0, max_gap)), noise);
    end
  endtask

  task automatic check_result(input string tag, input logic exp_done, input logic exp_err);
    check_bit({tag, "_done"}, done, exp_done);
    check_bit({tag, "_error"}, error, exp_err);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_ready"}, s_ready, 1'b0);
    check_bit({tag, "_cfg_valid"}, cfg_valid, m_valid);
    check_bit({tag, "_fab_rst"}, fabric_reset, !m_valid);
    check_vec({tag, "_cfg"}, cfg_bits, m_cfg);
  endtask

  initial begin
    logic [8*NBYTES-1:0] pl;
    logic [7:0]          h, cb;
    logic                ok;

    vt[0] = '{8'h5A, '0, 8'h00, 1'b0, 1'b1, 1'b0, '0};
    vt[1] = '{HDR, 128'h0F0E0D0C0B0A09080706050403020100, 8'h00, 1'b1, 1'b0, 1'b1,
              124'hF0E0D0C0B0A09080706050403020100};
    vt[2] = '{HDR, '1, 8'h00, 1'b1, 1'b0, 1'b1, '1};
    vt[3] = '{HDR, '1, 8'h01, 1'b0, 1'b1, 1'b1, '1};
    vt[4] = '{HDR, {16{8'h80}}, 8'h00, 1'b1, 1'b0, 1'b1, {4'h0, {15{8'h80}}}};
    vt[5] = '{HDR, 128'h1, 8'h00, 1'b0, 1'b1, 1'b1, {4'h0, {15{8'h80}}}};
    vt[6] = '{HDR, 128'h1, 8'h01, 1'b1, 1'b0, 1'b1, 124'h1};

    // reset and start asserted together: reset must win
    reset   = 1'b1;
    start   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_cfg   = '0;
    m_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    start = 1'b0;
    check_result("reset", 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      drive_frame(vt[i].hdr, vt[i].payload, vt[i].chk, 0, 1'b0);
      m_cfg   = vt[i].exp_cfg;
      m_valid = vt[i].exp_valid;
      check_result($sformatf("vec%0d", i), vt[i].exp_done, vt[i].exp_err);
    end

    // TIMEOUT-1 idle cycles after byte 5 -> error on the following cycle
    pl    = {$urandom(), $urandom(), $urandom(), $urandom()};
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(HDR, 0, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(pl[8*k +: 8], 0, 1'b0);
    repeat (TIMEOUT - 2) step();
    check_bit("to_not_yet", error, 1'b0);
    check_bit("to_still_busy", busy, 1'b1);
    step();
    check_result("timeout", 1'b0, 1'b1);

    // one idle cycle shorter, then resume: load succeeds
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(HDR, 0, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(pl[8*k +: 8], 0, 1'b0);
    send_byte(pl[8*6 +: 8], TIMEOUT - 2, 1'b0);
    for (int k = 7; k < NBYTES; k++) send_byte(pl[8*k +: 8], 0, 1'b0);
    send_byte(xor_bytes(pl), 0, 1'b0);
    m_cfg   = pl[CFG_BITS-1:0];
    m_valid = 1'b1;
    check_result("stall_ok", 1'b1, 1'b0);

    // reset after byte 8 of a partial frame, then a fresh all-zero frame
    start = 1'b1;
    step();
    start = 1'b0;
    send_byte(HDR, 0, 1'b0);
    for (int k = 0; k < 9; k++) send_byte(8'hEE, 0, 1'b0);
    reset = 1'b1;
    step();
    reset   = 1'b0;
    m_cfg   = '0;
    m_valid = 1'b0;
    check_result("midreset", 1'b0, 1'b0);
    drive_frame(HDR, '0, 8'h00, 0, 1'b0);
    m_valid = 1'b1;
    check_result("after_reset", 1'b1, 1'b0);

    // random frames with gaps, stray start pulses and occasional corruption
    for (int n = 0; n < 20; n++) begin
      pl = {$urandom(), $urandom(), $urandom(), $urandom()};
      h  = HDR;
      cb = xor_bytes(pl);
      case ($urandom_range(0, 3))
        0:       h  = HDR ^ 8'($urandom_range(1, 255));
        1:       cb = cb ^ 8'(1 << $urandom_range(0, 7));
        default: ;
      endcase
      drive_frame(h, pl, cb, 5, 1'b1);
      ok = (h == HDR) && (cb == xor_bytes(pl));
      if (ok) begin
        m_cfg   = pl[CFG_BITS-1:0];
        m_valid = 1'b1;
      end
      check_result($sformatf("rand%0d", n), ok, !ok);
      repeat ($urandom_range(1, 3)) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom);
        step();
        check_bit("idle_ready", s_ready, 1'b0);
      end
      s_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
